iob_reg_wr_arb: RTL

IOB_REG_WR_ARB -- requirements
Module: iob_reg_wr_arb

---
 rtl/iob_reg_wr_arb_pkg.sv | 12 +
 rtl/iob_reg_car.sv | 25 ++
 rtl/iob_reg_wr_arb.sv | 118 +++++++++++
 3 files changed

// File: rtl/iob_reg_wr_arb_pkg.sv
// Shared state encoding for the register-write arbiter.
package iob_reg_wr_arb_pkg;

    localparam int STATE_W = 2;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_WRITE = 2'd1;
    localparam state_t ST_ACK   = 2'd2;

endpackage

// File: rtl/iob_reg_car.sv
// Register with clock enable, active-high async reset and synchronous clear.
module iob_reg_car #(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    // Clear wins over enable so an aborted write cannot land.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            data_o <= RST_VAL;
        end else if (rst_i) begin
            data_o <= RST_VAL;
        end else if (cke_i) begin
            data_o <= data_i;
        end
    end

endmodule

// File: rtl/iob_reg_wr_arb.sv
// N-requester arbiter for one shared register: IDLE -> WRITE -> ACK.
// Define IOB_REG_WR_ARB_RR_EN for round-robin; default is fixed priority (lowest index).
module iob_reg_wr_arb
    import iob_reg_wr_arb_pkg::*;
#(
    parameter int                N_REQ   = 4,
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic                    clk_i,
    input  logic                    arst_n_i,
    input  logic                    cke_i,
    input  logic                    rst_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic [N_REQ-1:0]        grant_o,
    output logic                    busy_o,
    output logic [DATA_W-1:0]       data_o
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic              req_any;
    logic [DATA_W-1:0] wr_data;

    assign req_any = |req_valid_i;
    assign wr_data = req_data_i[int'(win_q)*DATA_W +: DATA_W];

`ifdef IOB_REG_WR_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q;

    // Search wraps from the pointer; the first valid requester wins.
    always_comb begin
        int  idx;
        logic found;
        win_d = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req_valid_i[idx]) begin
                win_d = IDX_W'(idx);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ptr_q <= '0;
        end else if (cke_i) begin
            if (rst_i) begin
                ptr_q <= '0;
            end else if (state_q == ST_ACK) begin
                ptr_q <= (win_q == IDX_W'(N_REQ-1)) ? '0 : win_q + 1'b1;
            end
        end
    end
`else
    always_comb begin
        win_d = '0;
        for (int i = N_REQ-1; i >= 0; i--) begin
            if (req_valid_i[i]) win_d = IDX_W'(i);
        end
    end
`endif

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
        end else if (cke_i) begin
            if (rst_i) begin
                state_q <= ST_IDLE;
                win_q   <= '0;
            end else begin
                state_q <= state_d;
                if (state_q == ST_IDLE && req_any) win_q <= win_d;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_any) state_d = ST_WRITE;
            ST_WRITE: state_d = ST_ACK;
            ST_ACK:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Grant spans WRITE and ACK; ready only in ACK.
    always_comb begin
        grant_o     = '0;
        req_ready_o = '0;
        busy_o      = (state_q != ST_IDLE);
        if (state_q != ST_IDLE) grant_o[win_q] = 1'b1;
        if (state_q == ST_ACK)  req_ready_o[win_q] = 1'b1;
    end

    iob_reg_car #(
        .DATA_W  (DATA_W),
        .RST_VAL (RST_VAL)
    ) u_shared_reg (
        .clk_i  (clk_i),
        .arst_i (~arst_n_i),
        .cke_i  (cke_i & (state_q == ST_WRITE)),
        .rst_i  (cke_i & rst_i),
        .data_i (wr_data),
        .data_o (data_o)
    );

endmodule
